// File: rtl/background_scroll_fade.sv
// Scrolling background fetch with 2^SHIFT upscaling and a frame-synchronous
// palette fade; the colour for a pixel coordinate appears three cycles later.
module background_scroll_fade #(
  parameter int SRC_W     = 320,
  parameter int SRC_H     = 240,
  parameter int SHIFT     = 1,
  parameter int ADDR_W    = 17,
  parameter int IDX_W     = 4,
  parameter int FADE_STEP = 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        scroll_x,
  input  logic [9:0]        scroll_y,
  input  logic              fade_in_req,
  input  logic              fade_out_req,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  input  logic [3:0]        palette_red,
  input  logic [3:0]        palette_green,
  input  logic [3:0]        palette_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              fade_busy,
  output logic              fade_done
);

  typedef enum logic [1:0] {BLACK, FADE_IN, SHOWN, FADE_OUT} fade_state_t;

  localparam logic [10:0]       SRC_W_L = 11'(SRC_W);
  localparam logic [10:0]       SRC_H_L = 11'(SRC_H);
  localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);
  localparam logic [5:0]        STEP_L  = 6'(FADE_STEP);

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
    return 4'(({4'b0, c} * {3'b0, lvl}) >> 4);
  endfunction

  fade_state_t       state_q, state_d, eff_state;
  logic [4:0]        level_q, level_d;
  logic [5:0]        level_up;
  logic              pend_in_q, pend_in_d, pend_out_q, pend_out_d;
  logic              fade_done_q, fade_done_d;
  logic [9:0]        scroll_x_lat_q, scroll_x_lat_d, scroll_y_lat_q, scroll_y_lat_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic              blank_p1_q, blank_p1_d, blank_p2_q, blank_p2_d;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              frame_start, in_range;
  logic [10:0]       hx, hy, sx_sum, sy_sum, sx, sy;

  // The ROM index itself only reaches us through the external palette lookup.
  logic unused_rom_q;
  assign unused_rom_q = ^rom_q;

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

  // The first pixel of a frame already uses the scroll value latched for it.
  always_comb begin
    scroll_x_lat_d = scroll_x_lat_q;
    scroll_y_lat_d = scroll_y_lat_q;
    if (frame_start && ({1'b0, scroll_x} < SRC_W_L)) scroll_x_lat_d = scroll_x;
    if (frame_start && ({1'b0, scroll_y} < SRC_H_L)) scroll_y_lat_d = scroll_y;
    hx       = {1'b0, DrawX} >> SHIFT;
    hy       = {1'b0, DrawY} >> SHIFT;
    sx_sum   = hx + {1'b0, scroll_x_lat_d};
    sy_sum   = hy + {1'b0, scroll_y_lat_d};
    sx       = (sx_sum >= SRC_W_L) ? (sx_sum - SRC_W_L) : sx_sum;
    sy       = (sy_sum >= SRC_H_L) ? (sy_sum - SRC_H_L) : sy_sum;
    in_range = blank && (hx < SRC_W_L) && (hy < SRC_H_L);
    rom_address_d = in_range ? (ADDR_W'(sy) * SRC_W_A + ADDR_W'(sx)) : rom_address_q;
  end

  // Pending requests are resolved on frame_start, then the same frame steps the level.
  always_comb begin
    state_d     = state_q;
    eff_state   = state_q;
    level_d     = level_q;
    level_up    = {1'b0, level_q} + STEP_L;
    pend_in_d   = pend_in_q;
    pend_out_d  = pend_out_q;
    fade_done_d = 1'b0;
    if (frame_start) begin
      pend_in_d  = 1'b0;
      pend_out_d = 1'b0;
      if (pend_out_q && (state_q == SHOWN || state_q == FADE_IN))
        eff_state = FADE_OUT;
      else if (pend_in_q && (state_q == BLACK || state_q == FADE_OUT))
        eff_state = FADE_IN;
      state_d = eff_state;
      case (eff_state)
        FADE_IN: begin
          if (level_up >= 6'd16) begin
            level_d     = 5'd16;
            state_d     = SHOWN;
            fade_done_d = 1'b1;
          end else begin
            level_d = level_up[4:0];
          end
        end
        FADE_OUT: begin
          if ({1'b0, level_q} <= STEP_L) begin
            level_d     = 5'd0;
            state_d     = BLACK;
            fade_done_d = 1'b1;
          end else begin
            level_d = level_q - STEP_L[4:0];
          end
        end
        default: ;
      endcase
    end
    if (fade_out_req) begin
      pend_out_d = 1'b1;
      pend_in_d  = 1'b0;
    end else if (fade_in_req) begin
      pend_in_d  = 1'b1;
      pend_out_d = 1'b0;
    end
  end

  // The colour register is the third blank stage, aligned with rom_q/palette.
  always_comb begin
    blank_p1_d = blank;
    blank_p2_d = blank_p1_q;
    red_d      = blank_p2_q ? scale(palette_red,   level_q) : 4'd0;
    green_d    = blank_p2_q ? scale(palette_green, level_q) : 4'd0;
    blue_d     = blank_p2_q ? scale(palette_blue,  level_q) : 4'd0;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q        <= SHOWN;
      level_q        <= 5'd16;
      pend_in_q      <= 1'b0;
      pend_out_q     <= 1'b0;
      fade_done_q    <= 1'b0;
      scroll_x_lat_q <= 10'd0;
      scroll_y_lat_q <= 10'd0;
      rom_address_q  <= '0;
      blank_p1_q     <= 1'b0;
      blank_p2_q     <= 1'b0;
      red_q          <= 4'd0;
      green_q        <= 4'd0;
      blue_q         <= 4'd0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      pend_in_q      <= pend_in_d;
      pend_out_q     <= pend_out_d;
      fade_done_q    <= fade_done_d;
      scroll_x_lat_q <= scroll_x_lat_d;
      scroll_y_lat_q <= scroll_y_lat_d;
      rom_address_q  <= rom_address_d;
      blank_p1_q     <= blank_p1_d;
      blank_p2_q     <= blank_p2_d;
      red_q          <= red_d;
      green_q        <= green_d;
      blue_q         <= blue_d;
    end
  end

  assign rom_address = rom_address_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign fade_busy   = (state_q == FADE_IN) || (state_q == FADE_OUT);
  assign fade_done   = fade_done_q;

endmodule

// File: tb/tb_background_scroll_fade.sv
// Bench for background_scroll_fade: directed address table, fade sequences and
// randomized traffic checked against an arithmetic reference model every cycle.
module tb_background_scroll_fade;

  localparam int SRC_W     = 320;
  localparam int SRC_H     = 240;
  localparam int SHIFT     = 1;
  localparam int ADDR_W    = 17;
  localparam int IDX_W     = 4;
  localparam int FADE_STEP = 1;

  logic              vga_clk = 1'b0;
  logic              reset;
  logic [9:0]        DrawX, DrawY, scroll_x, scroll_y;
  logic              blank, fade_in_req, fade_out_req;
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [3:0]        palette_red, palette_green, palette_blue;
  logic [3:0]        red, green, blue;
  logic              fade_busy, fade_done;

  always #5 vga_clk = ~vga_clk;

  background_scroll_fade #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .SHIFT(SHIFT), .ADDR_W(ADDR_W),
    .IDX_W(IDX_W), .FADE_STEP(FADE_STEP)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .fade_in_req(fade_in_req), .fade_out_req(fade_out_req),
    .rom_address(rom_address), .rom_q(rom_q),
    .palette_red(palette_red), .palette_green(palette_green), .palette_blue(palette_blue),
    .red(red), .green(green), .blue(blue),
    .fade_busy(fade_busy), .fade_done(fade_done)
  );

  function automatic logic [3:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction
  function automatic int pal_r(input int v); return v & 15; endfunction
  function automatic int pal_g(input int v); return (~v) & 15; endfunction
  function automatic int pal_b(input int v); return (v ^ 5) & 15; endfunction

  // External synchronous ROM and combinational palette
  always @(posedge vga_clk) rom_q <= rom_fn(rom_address);
  assign palette_red   = 4'(pal_r(int'(rom_q)));
  assign palette_green = 4'(pal_g(int'(rom_q)));
  assign palette_blue  = 4'(pal_b(int'(rom_q)));

  // Reference model: latched scroll, fade level/direction, pending request
  int m_latx, m_laty, m_level, m_dir, m_pend, m_addr;
  bit m_done;
  int a_hist[16], l_hist[16];
  bit b_hist[16];
  int cyc, checks, errors, done_seen;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input bit b, input int scx,
                               input int scy, input bit fin, input bit fout, input bit rst);
    int k, hx, hy, m, rv, lv;
    bit bv;
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    scroll_x = 10'(scx); scroll_y = 10'(scy);
    fade_in_req = fin; fade_out_req = fout; reset = rst;
    k = cyc;
    b_hist[k % 16] = rst ? 1'b0 : b;
    m_done = 1'b0;
    if (rst) begin
      if (k >= 1) b_hist[(k - 1) % 16] = 1'b0;
      if (k >= 2) b_hist[(k - 2) % 16] = 1'b0;
      m_latx = 0; m_laty = 0; m_level = 16; m_dir = 0; m_pend = 0; m_addr = 0;
    end else begin
      if (x == 0 && y == 0) begin
        if (scx < SRC_W) m_latx = scx;
        if (scy < SRC_H) m_laty = scy;
        if (m_pend == 2 && !(m_dir == 0 && m_level == 0)) m_dir = -1;
        else if (m_pend == 1 && !(m_dir == 0 && m_level == 16)) m_dir = 1;
        if (m_dir == 1) begin
          m_level = (m_level + FADE_STEP > 16) ? 16 : m_level + FADE_STEP;
          if (m_level == 16) begin m_dir = 0; m_done = 1'b1; end
        end else if (m_dir == -1) begin
          m_level = (m_level - FADE_STEP < 0) ? 0 : m_level - FADE_STEP;
          if (m_level == 0) begin m_dir = 0; m_done = 1'b1; end
        end
        m_pend = 0;
      end
      if (fout) m_pend = 2;
      else if (fin) m_pend = 1;
      hx = x >> SHIFT;
      hy = y >> SHIFT;
      if (b && hx < SRC_W && hy < SRC_H)
        m_addr = ((hy + m_laty) % SRC_H) * SRC_W + ((hx + m_latx) % SRC_W);
    end
    @(posedge vga_clk);
    #1;
    cyc++;
    a_hist[cyc % 16] = m_addr;
    l_hist[cyc % 16] = m_level;
    if (fade_done) done_seen++;
    checkOutput("rom_address", int'(rom_address), m_addr);
    checkOutput("fade_busy", int'(fade_busy), (m_dir != 0) ? 1 : 0);
    checkOutput("fade_done", int'(fade_done), int'(m_done));
    if (cyc >= 3) begin
      m  = cyc;
      rv = int'(rom_fn(ADDR_W'(a_hist[(m - 2) % 16])));
      bv = b_hist[(m - 3) % 16];
      lv = l_hist[(m - 1) % 16];
      checkOutput("red",   int'(red),   bv ? pal_r(rv) * lv / 16 : 0);
      checkOutput("green", int'(green), bv ? pal_g(rv) * lv / 16 : 0);
      checkOutput("blue",  int'(blue),  bv ? pal_b(rv) * lv / 16 : 0);
    end
  endtask

  task automatic pixel(input int x, input int y);
    applyStimulus(x, y, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Pixel (30,0) maps to address 15 whose palette red is 4'hF.
  task automatic sample_red(output int r);
    pixel(30, 0); pixel(31, 0); pixel(32, 0);
    r = int'(red);
  endtask

  typedef struct {
    int x; int y; bit b; int scx; int scy; int exp_addr;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int r, done_before;
    tbl[0]  = '{0,   0,   1'b1, 0,   0,   0};
    tbl[1]  = '{5,   3,   1'b1, 0,   0,   322};
    tbl[2]  = '{0,   0,   1'b1, 319, 0,   319};
    tbl[3]  = '{4,   0,   1'b1, 319, 0,   1};
    tbl[4]  = '{0,   0,   1'b1, 400, 250, 319};
    tbl[5]  = '{4,   2,   1'b1, 400, 250, 321};
    tbl[6]  = '{10,  2,   1'b1, 5,   7,   324};
    tbl[7]  = '{10,  2,   1'b0, 5,   7,   324};
    tbl[8]  = '{700, 2,   1'b1, 5,   7,   324};
    tbl[9]  = '{0,   500, 1'b1, 5,   7,   324};
    tbl[10] = '{0,   0,   1'b1, 0,   239, 76480};
    tbl[11] = '{2,   4,   1'b1, 0,   239, 321};

    cyc = 0; checks = 0; errors = 0; done_seen = 0;
    for (int i = 0; i < 4; i++) applyStimulus(7, 7, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_rom_address", int'(rom_address), 0);
    checkOutput("reset_red", int'(red), 0);
    checkOutput("reset_busy", int'(fade_busy), 0);
    checkOutput("reset_done", int'(fade_done), 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].scx, tbl[i].scy, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("table_addr_%0d", i), int'(rom_address), tbl[i].exp_addr);
    end

    pixel(0, 0);
    sample_red(r);
    checkOutput("shown_red", r, 15);

    // Fade out from SHOWN over 16 frames
    done_before = done_seen;
    applyStimulus(30, 0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    pixel(0, 0);
    checkOutput("fade_out_busy", int'(fade_busy), 1);
    sample_red(r);
    checkOutput("fade_out_level15", r, 14);
    for (int i = 2; i <= 16; i++) begin
      pixel(0, 0);
      if (i == 8) begin
        sample_red(r);
        checkOutput("fade_out_level8", r, 7);
      end
    end
    checkOutput("fade_out_done_count", done_seen - done_before, 1);
    checkOutput("black_busy", int'(fade_busy), 0);
    sample_red(r);
    checkOutput("black_red", r, 0);

    // Back to SHOWN, then simultaneous requests: fade_out wins
    applyStimulus(30, 0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) pixel(0, 0);
    sample_red(r);
    checkOutput("faded_in_red", r, 15);
    applyStimulus(30, 0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
    pixel(0, 0);
    checkOutput("both_req_busy", int'(fade_busy), 1);
    sample_red(r);
    checkOutput("both_req_out_wins", r, 14);

    // Reversal at level 10 continues upward from there
    for (int i = 0; i < 5; i++) pixel(0, 0);
    sample_red(r);
    checkOutput("level10_red", r, 9);
    applyStimulus(30, 0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0);
    pixel(0, 0);
    sample_red(r);
    checkOutput("reversal_level11", r, 10);

    // Reset mid FADE_IN aborts without fade_done
    done_before = done_seen;
    applyStimulus(30, 0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_busy", int'(fade_busy), 0);
    checkOutput("abort_red", int'(red), 0);
    sample_red(r);
    checkOutput("abort_level16", r, 15);
    checkOutput("abort_no_done", done_seen - done_before, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int x, y;
      if ($urandom_range(0, 19) == 0) begin
        x = 0; y = 0;
      end else begin
        x = $urandom_range(0, 720);
        y = $urandom_range(0, 520);
      end
      applyStimulus(x, y, ($urandom_range(0, 3) != 0), $urandom_range(0, 400),
                    $urandom_range(0, 300), ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 29) == 0), ($urandom_range(0, 499) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
